// File: rtl/bru_target_ras.sv
// EX-stage branch/jump target unit with a return-address stack.
// Targets are registered behind a valid/ready handshake; BL pushes its link address and a JIRL return pops a predicted target.
module bru_target_ras #(
    parameter int         XLEN      = 32,
    parameter int         RAS_DEPTH = 8,
    parameter int         PTR_W     = $clog2(RAS_DEPTH),
    parameter logic [7:0] OP_JIRL   = 8'h13,
    parameter logic [7:0] OP_B      = 8'h14,
    parameter logic [7:0] OP_BL     = 8'h15
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_op,
    input  logic [XLEN-1:0]  in_rj,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [25:0]      in_offset,
    input  logic [4:0]       in_rj_idx,
    input  logic [4:0]       in_rd_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_target,
    output logic             out_pred_valid,
    output logic [XLEN-1:0]  out_pred_target,
    output logic             out_ras_hit,
    output logic [PTR_W:0]   ras_count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(RAS_DEPTH);

    logic [XLEN-1:0] r_stack [RAS_DEPTH];
    logic [PTR_W-1:0] r_sp;
    logic [PTR_W:0]   r_count;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_target;
    logic             r_pred_valid;
    logic [XLEN-1:0]  r_pred_target;
    logic             r_ras_hit;

    logic             w_accept;
    logic             w_is_ret;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_sp_dec;
    logic [XLEN-1:0]  w_imm16;
    logic [XLEN-1:0]  w_imm26;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_pred_target;

    assign in_ready = (!r_out_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    assign w_imm16 = {{(XLEN - 18){in_offset[15]}}, in_offset[15:0], 2'b00};
    assign w_imm26 = {{(XLEN - 28){in_offset[25]}}, in_offset, 2'b00};

    always_comb begin
        w_target = in_pc + w_imm16;
        if (in_op == OP_JIRL)
            w_target = in_rj + w_imm16;
        else if (in_op == OP_B || in_op == OP_BL)
            w_target = in_pc + w_imm26;
    end

    // A return is the canonical "jirl r0, r1, off" form; anything else through JIRL is an indirect jump.
    assign w_is_ret      = (in_op == OP_JIRL) && (in_rj_idx == 5'd1) && (in_rd_idx == 5'd0);
    assign w_push        = w_accept && (in_op == OP_BL);
    assign w_pop         = w_accept && w_is_ret && (r_count != '0);
    assign w_sp_dec      = r_sp - PTR_W'(1);
    assign w_pred_target = w_pop ? r_stack[w_sp_dec] : '0;

    // Stack contents carry no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push)
            r_stack[r_sp] <= in_pc + XLEN'(4);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sp    <= '0;
            r_count <= '0;
        end else if (w_push) begin
            r_sp <= r_sp + PTR_W'(1);
            if (r_count != FULL_CNT)
                r_count <= r_count + 1'b1;
        end else if (w_pop) begin
            r_sp    <= w_sp_dec;
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid   <= 1'b0;
            r_out_target  <= '0;
            r_pred_valid  <= 1'b0;
            r_pred_target <= '0;
            r_ras_hit     <= 1'b0;
        end else if (flush) begin
            r_out_valid   <= 1'b0;
            r_pred_valid  <= 1'b0;
            r_pred_target <= '0;
            r_ras_hit     <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_target  <= w_target;
            r_pred_valid  <= w_pop;
            r_pred_target <= w_pred_target;
            r_ras_hit     <= w_pop && (w_pred_target == w_target);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid       = r_out_valid;
    assign out_target      = r_out_target;
    assign out_pred_valid  = r_pred_valid;
    assign out_pred_target = r_pred_target;
    assign out_ras_hit     = r_ras_hit;
    assign ras_count       = r_count;

endmodule

// File: tb/tb_bru_target_ras.sv
// Randomized and directed bench for bru_target_ras against a queue-based behavioural model.
module tb_bru_target_ras;

    localparam int         XLEN    = 32;
    localparam int         DEPTH   = 8;
    localparam logic [7:0] OP_JIRL = 8'h13;
    localparam logic [7:0] OP_B    = 8'h14;
    localparam logic [7:0] OP_BL   = 8'h15;
    localparam logic [7:0] OP_BEQ  = 8'h16;
    localparam logic [7:0] OP_BNE  = 8'h17;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      in_op = '0;
    logic [XLEN-1:0] in_rj = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic [25:0]     in_offset = '0;
    logic [4:0]      in_rj_idx = '0;
    logic [4:0]      in_rd_idx = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_target;
    logic            out_pred_valid;
    logic [XLEN-1:0] out_pred_target;
    logic            out_ras_hit;
    logic [3:0]      ras_count;

    bru_target_ras #(.XLEN(XLEN), .RAS_DEPTH(DEPTH), .OP_JIRL(OP_JIRL), .OP_B(OP_B), .OP_BL(OP_BL)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rj(in_rj), .in_pc(in_pc),
        .in_offset(in_offset), .in_rj_idx(in_rj_idx), .in_rd_idx(in_rd_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_target(out_target),
        .out_pred_valid(out_pred_valid), .out_pred_target(out_pred_target),
        .out_ras_hit(out_ras_hit), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: the RAS is a bounded queue, newest entry at the back.
    logic [XLEN-1:0] m_ras[$];
    logic            m_valid;
    logic [XLEN-1:0] m_target;
    logic            m_pvalid;
    logic [XLEN-1:0] m_ptarget;
    logic            m_hit;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ras.delete();
        m_valid = 0; m_target = '0; m_pvalid = 0; m_ptarget = '0; m_hit = 0;
    endtask

    function automatic logic [XLEN-1:0] ref_target(logic [7:0] op, logic [XLEN-1:0] pc,
                                                   logic [XLEN-1:0] rj, logic [25:0] off);
        logic signed [17:0] s16;
        logic signed [27:0] s26;
        s16 = {off[15:0], 2'b00};
        s26 = {off, 2'b00};
        if (op == OP_JIRL) return rj + XLEN'(s16);
        if (op == OP_B || op == OP_BL) return pc + XLEN'(s26);
        return pc + XLEN'(s16);
    endfunction

    task automatic model_edge(input logic vld, input logic [7:0] op, input logic [XLEN-1:0] pc,
                              input logic [XLEN-1:0] rj, input logic [25:0] off,
                              input logic [4:0] rji, input logic [4:0] rdi,
                              input logic ordy, input logic fl);
        logic            rdy;
        logic [XLEN-1:0] tgt;
        rdy = (!m_valid || ordy) && !fl;
        if (fl) begin
            m_valid = 0; m_pvalid = 0; m_ptarget = '0; m_hit = 0;
        end else if (vld && rdy) begin
            tgt = ref_target(op, pc, rj, off);
            m_pvalid = 0; m_ptarget = '0;
            if (op == OP_BL) begin
                m_ras.push_back(pc + 4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            if (op == OP_JIRL && rji == 5'd1 && rdi == 5'd0 && m_ras.size() > 0) begin
                m_pvalid = 1;
                m_ptarget = m_ras.pop_back();
            end
            m_valid = 1; m_target = tgt; m_hit = m_pvalid && (m_ptarget == tgt);
        end else if (ordy) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, ".out_target"}, 64'(out_target), 64'(m_target));
        check({tag, ".pred_valid"}, 64'(out_pred_valid), 64'(m_pvalid));
        check({tag, ".pred_target"}, 64'(out_pred_target), 64'(m_ptarget));
        check({tag, ".ras_hit"}, 64'(out_ras_hit), 64'(m_hit));
        check({tag, ".ras_count"}, 64'(ras_count), 64'(m_ras.size()));
    endtask

    // Called right after a negedge: drive, check in_ready, clock, check registered outputs.
    task automatic cyc(input string tag, input logic vld, input logic [7:0] op,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rj, input logic [25:0] off,
                       input logic [4:0] rji, input logic [4:0] rdi, input logic ordy, input logic fl);
        in_valid = vld; in_op = op; in_pc = pc; in_rj = rj; in_offset = off;
        in_rj_idx = rji; in_rd_idx = rdi; out_ready = ordy; flush = fl;
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'((!m_valid || ordy) && !fl));
        @(posedge clk);
        model_edge(vld, op, pc, rj, off, rji, rdi, ordy, fl);
        @(negedge clk);
        check_outputs(tag);
        $display("%s: op=%0h pc=%0h acc=%0b -> v=%0b tgt=%0h pv=%0b pt=%0h hit=%0b cnt=%0d",
                 tag, op, pc, in_ready, out_valid, out_target, out_pred_valid,
                 out_pred_target, out_ras_hit, ras_count);
    endtask

    task automatic idle();
        cyc("idle", 0, OP_BEQ, '0, '0, '0, 0, 0, 1, 0);
    endtask

    initial begin
        logic [7:0]      op;
        logic [4:0]      rji, rdi;
        logic [XLEN-1:0] tgt_hold;
        logic [3:0]      cnt_hold;

        model_reset();
        resetn = 1'b0;
        #12;
        check_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        // OP_B with negative 26-bit offset
        cyc("b_neg", 1, OP_B, 32'h1C000000, '0, 26'h3FFFFFF, 0, 0, 1, 0);
        check("b_neg.const", 64'(out_target), 64'h1BFFFFFC);
        idle();

        // BL then matching return
        cyc("bl", 1, OP_BL, 32'h1C000100, '0, 26'h10, 0, 1, 1, 0);
        cyc("ret", 1, OP_JIRL, '0, 32'h1C000104, '0, 1, 0, 1, 0);
        check("ret.pred_const", 64'(out_pred_target), 64'h1C000104);
        check("ret.hit_const", 64'(out_ras_hit), 64'd1);
        check("ret.cnt_const", 64'(ras_count), 64'd0);

        // Overflow: 9 pushes into an 8-deep stack, then 9 returns
        for (int i = 1; i <= 9; i++) begin
            cyc("ovf_push", 1, OP_BL, 32'(i * 32'h100), '0, 26'h4, 0, 1, 1, 0);
            check("ovf_push.cnt", 64'(ras_count), 64'(i > 8 ? 8 : i));
        end
        for (int i = 9; i >= 1; i--) begin
            cyc("ovf_pop", 1, OP_JIRL, '0, 32'(i * 32'h100 + 4), '0, 1, 0, 1, 0);
            if (i >= 2) check("ovf_pop.pred", 64'(out_pred_target), 64'(i * 32'h100 + 4));
            else check("ovf_pop.empty_pv", 64'(out_pred_valid), 64'd0);
        end

        // Return with empty stack
        cyc("ret_empty", 1, OP_JIRL, '0, 32'h2000, 26'h000FFFF, 1, 0, 1, 0);
        check("ret_empty.tgt", 64'(out_target), 64'h1FFC);

        // Stall for 3 cycles, then release
        cyc("stall_ld", 1, OP_BL, 32'h3000, '0, 26'h8, 0, 1, 1, 0);
        tgt_hold = out_target;
        cnt_hold = ras_count;
        for (int i = 0; i < 3; i++) begin
            cyc("stall", 1, OP_BL, 32'h4000, '0, 26'h8, 0, 1, 0, 0);
            check("stall.tgt_stable", 64'(out_target), 64'(tgt_hold));
            check("stall.cnt_stable", 64'(ras_count), 64'(cnt_hold));
        end
        cyc("release", 1, OP_BEQ, 32'h5000, '0, 26'h1, 0, 0, 1, 0);
        check("release.tgt", 64'(out_target), 64'h5004);

        // Flush alongside a BL
        cnt_hold = ras_count;
        cyc("flush", 1, OP_BL, 32'h6000, '0, 26'h8, 0, 1, 1, 1);
        check("flush.cnt", 64'(ras_count), 64'(cnt_hold));

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 4))
                0: op = OP_JIRL; 1: op = OP_B; 2: op = OP_BL; 3: op = OP_BEQ; default: op = OP_BNE;
            endcase
            rji = 5'($urandom); rdi = 5'($urandom);
            if (op == OP_JIRL && $urandom_range(0, 1) == 1) begin rji = 5'd1; rdi = 5'd0; end
            cyc("rand", $urandom_range(0, 3) != 0, op, $urandom, $urandom, 26'($urandom),
                rji, rdi, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end

        // Asynchronous reset mid-stall
        cyc("pre_rst", 1, OP_BL, 32'h7000, '0, 26'h4, 0, 1, 1, 0);
        cyc("pre_rst_stall", 1, OP_B, 32'h8000, '0, 26'h4, 0, 1, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        resetn = 1'b1;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
